msp430_fetch_seq: RTL and testbench

//  Parametrised instruction fetch/decode sequencer replacing the latch-on-fail-condition decoder scheme.

---
 rtl/msp430_fetch_seq_pkg.sv | 68 ++++++
 rtl/msp430_ext_len.sv | 54 +++++
 rtl/msp430_fetch_seq.sv | 184 ++++++++++++++++++
 tb/tb_msp430_fetch_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/msp430_fetch_seq_pkg.sv
// rtl/msp430_fetch_seq_pkg.sv - opcode, function-select, format and state encodings shared with execute
package msp430_fetch_seq_pkg;

   typedef enum logic [1:0] {
      FMT_NONE = 2'd0,
      FMT_I    = 2'd1,
      FMT_II   = 2'd2,
      FMT_J    = 2'd3
   } fmt_e;

   typedef enum logic [1:0] {
      FETCH_OP  = 2'd0,
      FETCH_SRC = 2'd1,
      FETCH_DST = 2'd2,
      ISSUE     = 2'd3
   } state_e;

   // Double-operand opcodes live in opcode[15:12]
   localparam logic [3:0] OP_MOV  = 4'h4;
   localparam logic [3:0] OP_ADD  = 4'h5;
   localparam logic [3:0] OP_ADDC = 4'h6;
   localparam logic [3:0] OP_SUBC = 4'h7;
   localparam logic [3:0] OP_SUB  = 4'h8;
   localparam logic [3:0] OP_CMP  = 4'h9;
   localparam logic [3:0] OP_DADD = 4'hA;
   localparam logic [3:0] OP_BIT  = 4'hB;
   localparam logic [3:0] OP_BIC  = 4'hC;
   localparam logic [3:0] OP_BIS  = 4'hD;
   localparam logic [3:0] OP_XOR  = 4'hE;
   localparam logic [3:0] OP_AND  = 4'hF;

   // Single-operand group prefix and its op field (opcode[9:7])
   localparam logic [5:0] OP_FMT2_PFX = 6'b000100;
   localparam logic [2:0] OP2_RRC     = 3'b000;
   localparam logic [2:0] OP2_SWPB    = 3'b001;
   localparam logic [2:0] OP2_RRA     = 3'b010;
   localparam logic [2:0] OP2_SXT     = 3'b011;
   localparam logic [2:0] OP2_PUSH    = 3'b100;
   localparam logic [2:0] OP2_CALL    = 3'b101;
   localparam logic [2:0] OP2_RETI    = 3'b110;
   localparam logic [2:0] OP2_BAD     = 3'b111;
   localparam logic [2:0] OP_JMP_PFX  = 3'b001;

   // Function-select: 0x04..0x0F double-op, 0x10..0x16 single-op, 0x20..0x27 jumps
   localparam logic [5:0] FS_NONE = 6'h00;
   localparam logic [5:0] FS_MOV  = 6'h04;
   localparam logic [5:0] FS_ADD  = 6'h05;
   localparam logic [5:0] FS_CMP  = 6'h09;
   localparam logic [5:0] FS_BIT  = 6'h0B;
   localparam logic [5:0] FS_AND  = 6'h0F;
   localparam logic [5:0] FS_RRC  = 6'h10;
   localparam logic [5:0] FS_RETI = 6'h16;
   localparam logic [5:0] FS_JNE  = 6'h20;
   localparam logic [5:0] FS_JMP  = 6'h27;

   function automatic logic [5:0] fs_code(input fmt_e fmt, input logic [15:0] op);
      logic [5:0] fs;
      fs = FS_NONE;
      case (fmt)
         FMT_I:   fs = {2'b00, op[15:12]};
         FMT_II:  fs = FS_RRC | {3'b000, op[9:7]};
         FMT_J:   fs = FS_JNE | {3'b000, op[12:10]};
         default: fs = FS_NONE;
      endcase
      return fs;
   endfunction

endpackage

// File: rtl/msp430_ext_len.sv
// rtl/msp430_ext_len.sv - opcode -> format, extension-word needs, illegal flag (MSP430_ILLEGAL_TRAP_EN)
module msp430_ext_len
   import msp430_fetch_seq_pkg::*;
(
   input  logic [15:0] opcode_i,
   output fmt_e        fmt_o,
   output logic        src_ext_o,
   output logic        dst_ext_o,
   output logic        illegal_o
);

   logic       is_fmt1;
   logic       is_fmt2_grp;
   logic       is_jmp;
   logic       bad_op;
   logic [3:0] src_reg;
   logic [1:0] src_as;
   logic       src_needs_word;

   assign is_fmt1     = (opcode_i[15:12] >= OP_MOV);
   assign is_jmp      = (opcode_i[15:13] == OP_JMP_PFX);
   assign is_fmt2_grp = (opcode_i[15:10] == OP_FMT2_PFX);
   assign bad_op      = (opcode_i[15:12] == 4'h0) || (is_fmt2_grp && opcode_i[9:7] == OP2_BAD);

   assign src_reg = is_fmt1 ? opcode_i[11:8] : opcode_i[3:0];
   assign src_as  = opcode_i[5:4];

   // R3 in any mode and R2 in modes 1x are constant generators and need no word
   assign src_needs_word = (src_as == 2'b01 && src_reg != 4'd3) ||
                           (src_as == 2'b11 && src_reg == 4'd0);

   always_comb begin
      fmt_o     = FMT_NONE;
      src_ext_o = 1'b0;
      dst_ext_o = 1'b0;
      illegal_o = 1'b0;
      if (is_fmt1) begin
         fmt_o     = FMT_I;
         src_ext_o = src_needs_word;
         dst_ext_o = opcode_i[7];
      end else if (is_jmp) begin
         fmt_o = FMT_J;
      end else if (is_fmt2_grp && !bad_op) begin
         fmt_o     = FMT_II;
         src_ext_o = src_needs_word;
      end
`ifdef MSP430_ILLEGAL_TRAP_EN
      illegal_o = bad_op;
`else
      illegal_o = 1'b0;
`endif
   end

endmodule

// File: rtl/msp430_fetch_seq.sv
// rtl/msp430_fetch_seq.sv - instruction fetch/decode sequencer between program memory and execute
// Optional illegal-opcode flagging via MSP430_ILLEGAL_TRAP_EN (see msp430_ext_len).
module msp430_fetch_seq
   import msp430_fetch_seq_pkg::*;
#(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_STEP  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              fetch_req,
   output logic [ADDR_W-1:0] fetch_addr,
   input  logic              fetch_ack,
   input  logic [15:0]       fetch_data,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [15:0]       dec_instr,
   output logic [15:0]       dec_src_ext,
   output logic [15:0]       dec_dst_ext,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [1:0]        dec_fmt,
   output logic [5:0]        dec_fs,
   output logic [3:0]        dec_sa,
   output logic [3:0]        dec_da,
   output logic [1:0]        dec_as,
   output logic              dec_ad,
   output logic              dec_bw,
   output logic              dec_rw,
   output logic [1:0]        dec_len,
   output logic              dec_illegal
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] op_pc_q, op_pc_d;
   logic [15:0]       instr_q, instr_d;
   logic [15:0]       src_q, src_d;
   logic [15:0]       dst_q, dst_d;
   fmt_e              fmt_q, fmt_d;
   logic              need_src_q, need_src_d;
   logic              need_dst_q, need_dst_d;
   logic              ill_q, ill_d;

   fmt_e              nx_fmt;
   logic              nx_src, nx_dst, nx_ill;
   logic              issuing;

   msp430_ext_len u_ext_len (
      .opcode_i  (fetch_data),
      .fmt_o     (nx_fmt),
      .src_ext_o (nx_src),
      .dst_ext_o (nx_dst),
      .illegal_o (nx_ill)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FETCH_OP;
         pc_q       <= RESET_PC;
         op_pc_q    <= '0;
         instr_q    <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         fmt_q      <= FMT_NONE;
         need_src_q <= 1'b0;
         need_dst_q <= 1'b0;
         ill_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         op_pc_q    <= op_pc_d;
         instr_q    <= instr_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         fmt_q      <= fmt_d;
         need_src_q <= need_src_d;
         need_dst_q <= need_dst_d;
         ill_q      <= ill_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      op_pc_d    = op_pc_q;
      instr_d    = instr_q;
      src_d      = src_q;
      dst_d      = dst_q;
      fmt_d      = fmt_q;
      need_src_d = need_src_q;
      need_dst_d = need_dst_q;
      ill_d      = ill_q;
      if (flush) begin
         state_d = FETCH_OP;
         pc_d    = flush_pc;
      end else begin
         case (state_q)
            FETCH_OP: if (fetch_ack) begin
               instr_d    = fetch_data;
               op_pc_d    = pc_q;
               pc_d       = pc_q + STEP;
               fmt_d      = nx_fmt;
               need_src_d = nx_src;
               need_dst_d = nx_dst;
               ill_d      = nx_ill;
               src_d      = '0;
               dst_d      = '0;
               state_d    = nx_src ? FETCH_SRC : (nx_dst ? FETCH_DST : ISSUE);
            end
            FETCH_SRC: if (fetch_ack) begin
               src_d   = fetch_data;
               pc_d    = pc_q + STEP;
               state_d = need_dst_q ? FETCH_DST : ISSUE;
            end
            FETCH_DST: if (fetch_ack) begin
               dst_d   = fetch_data;
               pc_d    = pc_q + STEP;
               state_d = ISSUE;
            end
            ISSUE: if (dec_ready) begin
               state_d = FETCH_OP;
            end
            default: state_d = FETCH_OP;
         endcase
      end
   end

   // A flush in ISSUE suppresses valid so execute can never take the killed instruction
   assign issuing    = (state_q == ISSUE) && !flush;
   assign fetch_req  = rst_n && (state_q != ISSUE);
   assign fetch_addr = pc_q;
   assign dec_valid  = issuing;

   always_comb begin
      dec_instr   = '0;
      dec_src_ext = '0;
      dec_dst_ext = '0;
      dec_pc      = '0;
      dec_fmt     = FMT_NONE;
      dec_fs      = FS_NONE;
      dec_sa      = '0;
      dec_da      = '0;
      dec_as      = '0;
      dec_ad      = 1'b0;
      dec_bw      = 1'b0;
      dec_rw      = 1'b0;
      dec_len     = '0;
      dec_illegal = 1'b0;
      if (issuing) begin
         dec_instr   = instr_q;
         dec_src_ext = src_q;
         dec_dst_ext = dst_q;
         dec_pc      = op_pc_q;
         dec_fmt     = fmt_q;
         dec_fs      = fs_code(fmt_q, instr_q);
         dec_len     = 2'd1 + {1'b0, need_src_q} + {1'b0, need_dst_q};
         dec_illegal = ill_q;
         case (fmt_q)
            FMT_I: begin
               dec_sa = instr_q[11:8];
               dec_da = instr_q[3:0];
               dec_as = instr_q[5:4];
               dec_ad = instr_q[7];
               dec_bw = instr_q[6];
               dec_rw = (instr_q[15:12] != OP_CMP) && (instr_q[15:12] != OP_BIT);
            end
            FMT_II: begin
               dec_sa = instr_q[3:0];
               dec_da = instr_q[3:0];
               dec_as = instr_q[5:4];
               dec_bw = instr_q[6];
               dec_rw = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_msp430_fetch_seq.sv
// tb/tb_msp430_fetch_seq.sv - directed self-checking bench for msp430_fetch_seq
module tb_msp430_fetch_seq;

`ifdef MSP430_ILLEGAL_TRAP_EN
   localparam logic ILL = 1'b1;
`else
   localparam logic ILL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_ack = 1'b0;
   logic [15:0] fetch_data = '0;
   logic        flush = 1'b0;
   logic [15:0] flush_pc = '0;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [15:0] dec_instr, dec_src_ext, dec_dst_ext, dec_pc;
   logic [1:0]  dec_fmt, dec_as, dec_len;
   logic [5:0]  dec_fs;
   logic [3:0]  dec_sa, dec_da;
   logic        dec_ad, dec_bw, dec_rw, dec_illegal;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   msp430_fetch_seq #(.ADDR_W(16), .RESET_PC(16'h0000), .PC_STEP(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr),
      .fetch_ack(fetch_ack), .fetch_data(fetch_data),
      .flush(flush), .flush_pc(flush_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_instr(dec_instr), .dec_src_ext(dec_src_ext), .dec_dst_ext(dec_dst_ext),
      .dec_pc(dec_pc), .dec_fmt(dec_fmt), .dec_fs(dec_fs),
      .dec_sa(dec_sa), .dec_da(dec_da), .dec_as(dec_as), .dec_ad(dec_ad),
      .dec_bw(dec_bw), .dec_rw(dec_rw), .dec_len(dec_len), .dec_illegal(dec_illegal)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Entered just after a negedge; answers one fetch and returns at the next negedge
   task automatic serve(input string tag, input logic [15:0] a, input logic [15:0] d);
      int n;
      n = 0;
      #1;
      while (!fetch_req && n < 16) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, ".req"}, 32'(fetch_req), 32'd1);
      check({tag, ".addr"}, 32'(fetch_addr), 32'(a));
      fetch_ack  = 1'b1;
      fetch_data = d;
      @(negedge clk);
      fetch_ack  = 1'b0;
      fetch_data = '0;
   endtask

   task automatic take(input string tag, input logic [15:0] ins, input logic [15:0] src,
                       input logic [15:0] dst, input logic [15:0] pc, input logic [1:0] fmt,
                       input logic [5:0] fs, input logic [3:0] sa, input logic [3:0] da,
                       input logic [1:0] as, input logic ad, input logic bw, input logic rw,
                       input logic [1:0] len, input logic ill);
      #1;
      check({tag, ".valid"}, 32'(dec_valid), 32'd1);
      check({tag, ".instr"}, 32'(dec_instr), 32'(ins));
      check({tag, ".src"}, 32'(dec_src_ext), 32'(src));
      check({tag, ".dst"}, 32'(dec_dst_ext), 32'(dst));
      check({tag, ".pc"}, 32'(dec_pc), 32'(pc));
      check({tag, ".fmt"}, 32'(dec_fmt), 32'(fmt));
      check({tag, ".fs"}, 32'(dec_fs), 32'(fs));
      check({tag, ".sa_da"}, 32'({dec_sa, dec_da}), 32'({sa, da}));
      check({tag, ".as_ad_bw"}, 32'({dec_as, dec_ad, dec_bw}), 32'({as, ad, bw}));
      check({tag, ".rw"}, 32'(dec_rw), 32'(rw));
      check({tag, ".len"}, 32'(dec_len), 32'(len));
      check({tag, ".ill"}, 32'(dec_illegal), 32'(ill));
      dec_ready = 1'b1;
      @(negedge clk);
      dec_ready = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      check("rst.req", 32'(fetch_req), 32'd0);
      check("rst.valid", 32'(dec_valid), 32'd0);
      check("rst.instr", 32'(dec_instr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("boot.req", 32'(fetch_req), 32'd1);
      check("boot.addr", 32'(fetch_addr), 32'h0000);

      serve("mov_rr", 16'h0000, 16'h4506);
      take("mov_rr", 16'h4506, 16'h0, 16'h0, 16'h0000, 2'd1, 6'h04, 4'd5, 4'd6, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);

      serve("mov_imm.op", 16'h0002, 16'h4036);
      serve("mov_imm.x", 16'h0004, 16'h1234);
      take("mov_imm", 16'h4036, 16'h1234, 16'h0, 16'h0002, 2'd1, 6'h04, 4'd0, 4'd6, 2'd3, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);

      serve("add_idx.op", 16'h0006, 16'h5497);
      serve("add_idx.s", 16'h0008, 16'h0002);
      serve("add_idx.d", 16'h000A, 16'h0004);
      take("add_idx", 16'h5497, 16'h0002, 16'h0004, 16'h0006, 2'd1, 6'h05, 4'd4, 4'd7, 2'd1, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0);

      serve("mov_cg", 16'h000C, 16'h4316);
      take("mov_cg", 16'h4316, 16'h0, 16'h0, 16'h000C, 2'd1, 6'h04, 4'd3, 4'd6, 2'd1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);

      serve("jmp", 16'h000E, 16'h3C00);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stall.valid", 32'(dec_valid), 32'd1);
         check("stall.instr", 32'(dec_instr), 32'h3C00);
         check("stall.req", 32'(fetch_req), 32'd0);
         if (i == 1) begin
            fetch_ack  = 1'b1;
            fetch_data = 16'hBEEF;
         end
         @(negedge clk);
         fetch_ack  = 1'b0;
         fetch_data = '0;
      end
      take("jmp", 16'h3C00, 16'h0, 16'h0, 16'h000E, 2'd3, 6'h27, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

      serve("fl_src.op", 16'h0010, 16'h4036);
      #1;
      check("fl_src.pre_addr", 32'(fetch_addr), 32'h0012);
      flush      = 1'b1;
      flush_pc   = 16'h0100;
      fetch_ack  = 1'b1;
      fetch_data = 16'hDEAD;
      @(negedge clk);
      flush     = 1'b0;
      fetch_ack = 1'b0;
      #1;
      check("fl_src.addr", 32'(fetch_addr), 32'h0100);
      check("fl_src.valid", 32'(dec_valid), 32'd0);
      serve("after_fl", 16'h0100, 16'h4506);
      take("after_fl", 16'h4506, 16'h0, 16'h0, 16'h0100, 2'd1, 6'h04, 4'd5, 4'd6, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);

      serve("ill0", 16'h0102, 16'h0123);
      take("ill0", 16'h0123, 16'h0, 16'h0, 16'h0102, 2'd0, 6'h00, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, ILL);
      serve("ill7", 16'h0104, 16'h1380);
      take("ill7", 16'h1380, 16'h0, 16'h0, 16'h0104, 2'd0, 6'h00, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, ILL);
      serve("rra", 16'h0106, 16'h1105);
      take("rra", 16'h1105, 16'h0, 16'h0, 16'h0106, 2'd2, 6'h12, 4'd5, 4'd5, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);

      serve("fl_iss", 16'h0108, 16'h4506);
      #1;
      check("fl_iss.pre_valid", 32'(dec_valid), 32'd1);
      flush     = 1'b1;
      flush_pc  = 16'h0200;
      dec_ready = 1'b1;
      #1;
      check("fl_iss.valid", 32'(dec_valid), 32'd0);
      @(negedge clk);
      flush     = 1'b0;
      dec_ready = 1'b0;
      #1;
      check("fl_iss.addr", 32'(fetch_addr), 32'h0200);
      check("fl_iss.req", 32'(fetch_req), 32'd1);

      serve("rst_dst.op", 16'h0200, 16'h5497);
      serve("rst_dst.s", 16'h0202, 16'h0002);
      #1;
      check("rst_dst.pre_addr", 32'(fetch_addr), 32'h0204);
      rst_n = 1'b0;
      #1;
      check("rst_dst.req", 32'(fetch_req), 32'd0);
      check("rst_dst.valid", 32'(dec_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_dst.rel_req", 32'(fetch_req), 32'd1);
      check("rst_dst.rel_addr", 32'(fetch_addr), 32'h0000);

      flush    = 1'b1;
      flush_pc = 16'hFFFE;
      @(negedge clk);
      flush = 1'b0;
      serve("wrap", 16'hFFFE, 16'h4506);
      take("wrap", 16'h4506, 16'h0, 16'h0, 16'hFFFE, 2'd1, 6'h04, 4'd5, 4'd6, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
      #1;
      check("wrap.addr", 32'(fetch_addr), 32'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
